// File: rtl/exc_arbiter.sv
// Exception/interrupt/ERET arbiter: picks one event in IDLE, flushes the pipeline, then redirects the PC.
// Latency: acceptance at edge k -> Flush for FLUSH_CYC cycles, Redirect pulse in cycle k+FLUSH_CYC+1 (+2 for interrupts).
// Backpressure: none; events arriving while Busy are ignored and must be held by the pipeline until Busy drops.
module exc_arbiter #(
    parameter int          NSRC       = 4,
    parameter int          HWINT_W    = 6,
    parameter int          FLUSH_CYC  = 2,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC-1:0]      SrcExcGet,
    input  logic [5*NSRC-1:0]    SrcExcCode,
    input  logic [32*NSRC-1:0]   SrcPC,
    input  logic [NSRC-1:0]      SrcBD,
    input  logic [HWINT_W-1:0]   HWInt,
    input  logic [HWINT_W-1:0]   IM,
    input  logic                 IE,
    input  logic                 EXL,
    input  logic                 EretReq,
    input  logic [31:0]          EPCIn,
    output logic                 Flush,
    output logic                 Redirect,
    output logic [31:0]          RedirectPC,
    output logic [4:0]           ExcCodeOut,
    output logic [31:0]          EPCOut,
    output logic                 BDOut,
    output logic                 EPCWe,
    output logic                 SetEXL,
    output logic                 ClrEXL,
    output logic                 Busy
);

    localparam int                CNT_W    = $clog2(FLUSH_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [HWINT_W-1:0]   hw_s1_q, hw_s2_q;
    logic [4:0]           code_q, code_d;
    logic [31:0]          epc_q, epc_d;
    logic                 bd_q, bd_d;
    logic [31:0]          rpc_q, rpc_d;
    logic                 eret_q, eret_d;    // accepted event was an ERET
    logic                 nest_q, nest_d;    // EXL was already set at acceptance

    logic                 int_pend;
    logic                 sel_vld;
    logic [4:0]           sel_code;
    logic [31:0]          sel_pc;
    logic                 sel_bd;
    logic [4:0]           trap_code;
    logic [31:0]          trap_pc;
    logic                 trap_bd;

    // Two-flop synchronizer for the asynchronous interrupt lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hw_s1_q <= '0;
            hw_s2_q <= '0;
        end else begin
            hw_s1_q <= HWInt;
            hw_s2_q <= hw_s1_q;
        end
    end

    assign int_pend = (|(hw_s2_q & IM)) & IE & ~EXL;

    // Oldest (lowest-index) excepting slot wins; scan downward so index 0 is assigned last.
    always_comb begin
        sel_vld  = 1'b0;
        sel_code = '0;
        sel_pc   = '0;
        sel_bd   = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (SrcExcGet[i]) begin
                sel_vld  = 1'b1;
                sel_code = SrcExcCode[5*i +: 5];
                sel_pc   = SrcPC[32*i +: 32];
                sel_bd   = SrcBD[i];
            end
        end
    end

    // Interrupts are attributed to slot 0 with ExcCode 0.
    assign trap_code = int_pend ? 5'd0       : sel_code;
    assign trap_pc   = int_pend ? SrcPC[31:0] : sel_pc;
    assign trap_bd   = int_pend ? SrcBD[0]    : sel_bd;

    // Next-state logic: accept one event in IDLE, count down the flush, then one redirect cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        epc_d   = epc_q;
        bd_d    = bd_q;
        rpc_d   = rpc_q;
        eret_d  = eret_q;
        nest_d  = nest_q;
        case (state_q)
            S_IDLE: begin
                if (int_pend || sel_vld) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_LOAD;
                    code_d  = trap_code;
                    epc_d   = trap_bd ? (trap_pc - 32'd4) : trap_pc;
                    bd_d    = trap_bd;
                    rpc_d   = HANDLER_PC;
                    eret_d  = 1'b0;
                    nest_d  = EXL;
                end else if (EretReq) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_LOAD;
                    rpc_d   = EPCIn;
                    eret_d  = 1'b1;
                    nest_d  = EXL;
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_REDIRECT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_REDIRECT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and latched event registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            epc_q   <= '0;
            bd_q    <= 1'b0;
            rpc_q   <= '0;
            eret_q  <= 1'b0;
            nest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
            bd_q    <= bd_d;
            rpc_q   <= rpc_d;
            eret_q  <= eret_d;
            nest_q  <= nest_d;
        end
    end

    assign Busy       = (state_q != S_IDLE);
    assign Flush      = (state_q == S_FLUSH);
    assign Redirect   = (state_q == S_REDIRECT);
    assign SetEXL     = Redirect & ~eret_q;
    assign EPCWe      = Redirect & ~eret_q & ~nest_q;   // nested trap keeps the original EPC
    assign ClrEXL     = Redirect & eret_q;
    assign RedirectPC = rpc_q;
    assign ExcCodeOut = code_q;
    assign EPCOut     = epc_q;
    assign BDOut      = bd_q;

endmodule

// File: tb/tb_exc_arbiter.sv
// Testbench for exc_arbiter: directed scenarios plus randomized events against a reference model.
// Latency: checks the Flush/Redirect timeline cycle by cycle from the acceptance edge.
// Backpressure: drives junk while Busy to confirm it is dropped.
module tb_exc_arbiter;

    localparam int          NSRC = 4;
    localparam int          HW   = 6;
    localparam int          FC   = 2;
    localparam logic [31:0] HPC  = 32'h0000_4180;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NSRC-1:0]      SrcExcGet;
    logic [5*NSRC-1:0]    SrcExcCode;
    logic [32*NSRC-1:0]   SrcPC;
    logic [NSRC-1:0]      SrcBD;
    logic [HW-1:0]        HWInt, IM;
    logic                 IE, EXL, EretReq;
    logic [31:0]          EPCIn;
    logic                 Flush, Redirect, BDOut, EPCWe, SetEXL, ClrEXL, Busy;
    logic [31:0]          RedirectPC, EPCOut;
    logic [4:0]           ExcCodeOut;

    int checks = 0;
    int errors = 0;

    exc_arbiter #(.NSRC(NSRC), .HWINT_W(HW), .FLUSH_CYC(FC), .HANDLER_PC(HPC)) dut (
        .clk(clk), .reset(reset), .SrcExcGet(SrcExcGet), .SrcExcCode(SrcExcCode),
        .SrcPC(SrcPC), .SrcBD(SrcBD), .HWInt(HWInt), .IM(IM), .IE(IE), .EXL(EXL),
        .EretReq(EretReq), .EPCIn(EPCIn), .Flush(Flush), .Redirect(Redirect),
        .RedirectPC(RedirectPC), .ExcCodeOut(ExcCodeOut), .EPCOut(EPCOut), .BDOut(BDOut),
        .EPCWe(EPCWe), .SetEXL(SetEXL), .ClrEXL(ClrEXL), .Busy(Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          acc;
        bit          eret;
        logic [4:0]  code;
        logic [31:0] epc;
        bit          bd;
        logic [31:0] rpc;
        bit          epcwe;
    } exp_t;

    // Reference model: what the arbiter should accept given stable inputs at an IDLE edge.
    function automatic exp_t model(input logic [HW-1:0] hw, input logic [HW-1:0] im,
                                   input logic ie, input logic exl, input logic [NSRC-1:0] get,
                                   input logic [5*NSRC-1:0] codes, input logic [32*NSRC-1:0] pcs,
                                   input logic [NSRC-1:0] bds, input logic eret, input logic [31:0] epcin);
        exp_t        e;
        int          slot;
        bit          intr;
        logic [31:0] pc;
        e    = '{default: 0};
        intr = ((hw & im) != 0) && ie && !exl;
        slot = -1;
        if (intr) slot = 0;
        else for (int i = 0; i < NSRC; i++) if (get[i] && slot < 0) slot = i;
        if (slot >= 0) begin
            e.acc   = 1;
            e.code  = intr ? 5'd0 : codes[5*slot +: 5];
            pc      = pcs[32*slot +: 32];
            e.bd    = bds[slot];
            e.epc   = e.bd ? pc - 32'd4 : pc;
            e.rpc   = HPC;
            e.epcwe = !exl;
        end else if (eret) begin
            e.acc  = 1;
            e.eret = 1;
            e.rpc  = epcin;
        end
        return e;
    endfunction

    task automatic set_slot(input int i, input logic [4:0] code, input logic [31:0] pc, input logic bd);
        SrcExcCode[5*i +: 5] = code;
        SrcPC[32*i +: 32]    = pc;
        SrcBD[i]             = bd;
    endtask

    task automatic clear_inputs();
        SrcExcGet = '0; EretReq = 1'b0; IE = 1'b0; EXL = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; SrcExcCode = '0; SrcPC = '0; SrcBD = '0; HWInt = '0; IM = '0;
        EPCIn = '0; clear_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if ({Busy, Flush, Redirect, EPCWe, SetEXL, ClrEXL} !== 6'b0)
            begin errors++; $display("FAIL reset_ctrl: got %b want 000000", {Busy, Flush, Redirect, EPCWe, SetEXL, ClrEXL}); end
        checks++;
        if ({ExcCodeOut, EPCOut, BDOut, RedirectPC} !== 70'd0)
            begin errors++; $display("FAIL reset_data: code=%0d epc=%h bd=%b rpc=%h want all 0", ExcCodeOut, EPCOut, BDOut, RedirectPC); end
        reset = 1'b0;
    endtask

    task automatic test_exc_priority();
        @(negedge clk);
        set_slot(1, 5'd10, 32'h3008, 1'b0);
        set_slot(2, 5'd12, 32'h300C, 1'b0);
        SrcExcGet = 4'b0110;
        @(negedge clk);
        checks++;
        if ({Busy, Flush, Redirect} !== 3'b110) begin errors++; $display("FAIL prio_c1: got %b want 110", {Busy, Flush, Redirect}); end
        checks++;
        if (ExcCodeOut !== 5'd10 || EPCOut !== 32'h3008)
            begin errors++; $display("FAIL prio_data: code=%0d epc=%h want 10/00003008", ExcCodeOut, EPCOut); end
        SrcExcGet = '0;
        @(negedge clk);
        checks++;
        if ({Busy, Flush, Redirect} !== 3'b110) begin errors++; $display("FAIL prio_c2: got %b want 110", {Busy, Flush, Redirect}); end
        @(negedge clk);
        checks++;
        if ({Busy, Flush, Redirect, EPCWe, SetEXL, ClrEXL} !== 6'b101110 || RedirectPC !== HPC)
            begin errors++; $display("FAIL prio_redir: got %b rpc=%h want 101110 rpc=%h", {Busy, Flush, Redirect, EPCWe, SetEXL, ClrEXL}, RedirectPC, HPC); end
        @(negedge clk);
        checks++;
        if ({Busy, Flush, Redirect} !== 3'b000) begin errors++; $display("FAIL prio_idle: got %b want 000", {Busy, Flush, Redirect}); end
    endtask

    task automatic test_bd();
        set_slot(0, 5'd7, 32'h3010, 1'b1);
        SrcExcGet = 4'b0001;
        @(negedge clk);
        SrcExcGet = '0;
        checks++;
        if (EPCOut !== 32'h300C || BDOut !== 1'b1 || ExcCodeOut !== 5'd7)
            begin errors++; $display("FAIL bd: epc=%h bd=%b code=%0d want 0000300c/1/7", EPCOut, BDOut, ExcCodeOut); end
        repeat (3) @(negedge clk);
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL bd_idle: busy=%b want 0", Busy); end
    endtask

    task automatic test_interrupt();
        bit seen;
        set_slot(0, 5'd9, 32'h5000, 1'b0);
        HWInt = 6'b000100; IM = 6'b000100; IE = 1'b1; EXL = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            checks++;
            if (Busy !== (e == 3)) begin errors++; $display("FAIL int_lat edge%0d: busy=%b want %b", e, Busy, e == 3); end
        end
        checks++;
        if (ExcCodeOut !== 5'd0 || EPCOut !== 32'h5000)
            begin errors++; $display("FAIL int_data: code=%0d epc=%h want 0/00005000", ExcCodeOut, EPCOut); end
        IE = 1'b0;
        repeat (3) @(negedge clk);
        IM = '0; IE = 1'b1;
        seen = 0;
        repeat (5) begin @(negedge clk); if (Busy) seen = 1; end
        checks++;
        if (seen) begin errors++; $display("FAIL int_masked: busy seen=1 want 0"); end
        IM = 6'b000100; EXL = 1'b1;
        seen = 0;
        repeat (5) begin @(negedge clk); if (Busy) seen = 1; end
        checks++;
        if (seen) begin errors++; $display("FAIL int_exl: busy seen=1 want 0"); end
        clear_inputs(); HWInt = '0; IM = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_eret();
        EPCIn = 32'h3020; EretReq = 1'b1;
        @(negedge clk);
        EretReq = 1'b0; EPCIn = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        checks++;
        if ({Redirect, EPCWe, SetEXL, ClrEXL} !== 4'b1001 || RedirectPC !== 32'h3020)
            begin errors++; $display("FAIL eret: got %b rpc=%h want 1001 rpc=00003020", {Redirect, EPCWe, SetEXL, ClrEXL}, RedirectPC); end
        @(negedge clk);
    endtask

    task automatic test_nested();
        set_slot(0, 5'd4, 32'h3040, 1'b0);
        SrcExcGet = 4'b0001; EXL = 1'b1;
        @(negedge clk);
        SrcExcGet = '0; EXL = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({Redirect, EPCWe, SetEXL, ClrEXL} !== 4'b1010 || RedirectPC !== HPC)
            begin errors++; $display("FAIL nested: got %b rpc=%h want 1010 rpc=%h", {Redirect, EPCWe, SetEXL, ClrEXL}, RedirectPC, HPC); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_flush();
        bit seen;
        set_slot(0, 5'd13, 32'h3080, 1'b0);
        SrcExcGet = 4'b0001;
        @(posedge clk);
        #1;
        checks++;
        if (Flush !== 1'b1) begin errors++; $display("FAIL rst_pre: flush=%b want 1", Flush); end
        reset = 1'b1;
        #1;
        checks++;
        if ({Busy, Flush} !== 2'b00) begin errors++; $display("FAIL rst_async: got %b want 00", {Busy, Flush}); end
        @(negedge clk);
        SrcExcGet = '0;
        checks++;
        if (ExcCodeOut !== 5'd0) begin errors++; $display("FAIL rst_latch: code=%0d want 0", ExcCodeOut); end
        reset = 1'b0;
        seen = 0;
        repeat (4) begin @(negedge clk); if (Redirect || Busy) seen = 1; end
        checks++;
        if (seen) begin errors++; $display("FAIL rst_noredir: activity seen=1 want 0"); end
        SrcExcGet = 4'b0001;
        for (int c = 1; c <= FC + 2; c++) begin
            @(negedge clk);
            SrcExcGet = '0;
            checks++;
            if ({Busy, Flush, Redirect} !== {c <= FC + 1, c <= FC, c == FC + 1})
                begin errors++; $display("FAIL rst_after c%0d: got %b want %b", c, {Busy, Flush, Redirect}, {c <= FC + 1, c <= FC, c == FC + 1}); end
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int it = 0; it < 60; it++) begin
            @(negedge clk);
            clear_inputs();
            HWInt = HW'($urandom);
            repeat (2) @(negedge clk);
            IM         = HW'($urandom);
            IE         = 1'($urandom);
            EXL        = 1'($urandom);
            SrcExcGet  = ($urandom_range(0, 2) == 0) ? '0 : NSRC'($urandom);
            SrcExcCode = (5*NSRC)'($urandom);
            SrcPC      = {$urandom, $urandom, $urandom, $urandom};
            SrcBD      = NSRC'($urandom);
            EretReq    = 1'($urandom);
            EPCIn      = $urandom;
            e = model(HWInt, IM, IE, EXL, SrcExcGet, SrcExcCode, SrcPC, SrcBD, EretReq, EPCIn);
            for (int c = 1; c <= FC + 2; c++) begin
                @(negedge clk);
                checks++;
                if ({Busy, Flush, Redirect} !== {e.acc && c <= FC + 1, e.acc && c <= FC, e.acc && c == FC + 1})
                    begin errors++; $display("FAIL rnd_time it%0d c%0d: got %b want %b", it, c, {Busy, Flush, Redirect}, {e.acc && c <= FC + 1, e.acc && c <= FC, e.acc && c == FC + 1}); end
                if (e.acc && !e.eret && (c == 1 || c == FC + 1)) begin
                    checks++;
                    if (ExcCodeOut !== e.code || EPCOut !== e.epc || BDOut !== e.bd)
                        begin errors++; $display("FAIL rnd_data it%0d c%0d: code=%0d epc=%h bd=%b want %0d/%h/%b", it, c, ExcCodeOut, EPCOut, BDOut, e.code, e.epc, e.bd); end
                end
                if (e.acc && c == FC + 1) begin
                    checks++;
                    if (RedirectPC !== e.rpc || {EPCWe, SetEXL, ClrEXL} !== {e.epcwe, !e.eret, e.eret})
                        begin errors++; $display("FAIL rnd_redir it%0d: rpc=%h strobes=%b want %h/%b", it, RedirectPC, {EPCWe, SetEXL, ClrEXL}, e.rpc, {e.epcwe, !e.eret, e.eret}); end
                end else begin
                    checks++;
                    if ({EPCWe, SetEXL, ClrEXL} !== 3'b000)
                        begin errors++; $display("FAIL rnd_strobe it%0d c%0d: got %b want 000", it, c, {EPCWe, SetEXL, ClrEXL}); end
                end
                if (e.acc && c <= FC) begin
                    SrcExcGet = NSRC'($urandom); EretReq = 1'($urandom);
                    EXL = 1'($urandom); IE = 1'($urandom); EPCIn = $urandom;
                end else begin
                    clear_inputs();
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_exc_priority();
        test_bd();
        test_interrupt();
        test_eret();
        test_nested();
        test_reset_mid_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_arbiter.md
EXC_ARBITER -- requirements
Module: exc_arbiter

Interface
REQ-001 Parameter NSRC, default 4: number of pipeline exception sources; slot 0 is the oldest stage and has the highest priority.
REQ-002 Parameter HWINT_W, default 6: number of hardware interrupt lines.
REQ-003 Parameter FLUSH_CYC, default 2, legal range >=1: number of cycles Flush is held.
REQ-004 Parameter HANDLER_PC, default 32'h0000_4180: exception/interrupt handler entry address.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 SrcExcGet  in  NSRC  per-slot exception flag.
REQ-008 SrcExcCode  in  5*NSRC  packed ExcCode; slot i occupies [5i+4:5i].
REQ-009 SrcPC  in  32*NSRC  packed PC; slot i occupies [32i+31:32i].
REQ-010 SrcBD  in  NSRC  per-slot branch-delay-slot flag.
REQ-011 HWInt  in  HWINT_W  asynchronous interrupt lines.
REQ-012 IM  in  HWINT_W  interrupt mask.
REQ-013 IE, EXL  in  1 each  CP0 status bits.
REQ-014 EretReq  in  1  ERET has reached commit.
REQ-015 EPCIn  in  32  current CP0 EPC value.
REQ-016 Flush  out  1  pipeline flush request.
REQ-017 Redirect  out  1  one-cycle PC redirect pulse.
REQ-018 RedirectPC  out  32  redirect target.
REQ-019 ExcCodeOut  out  5  ExcCode to CP0 Cause.
REQ-020 EPCOut  out  32  EPC value to CP0.
REQ-021 BDOut  out  1  branch-delay flag to CP0 Cause.BD.
REQ-022 EPCWe, SetEXL, ClrEXL  out  1 each  one-cycle CP0 write strobes.
REQ-023 Busy  out  1  high whenever the state is not IDLE.

Function
REQ-024 HWInt shall pass through a 2-flop synchronizer. Define IntPend = |(HWInt_sync & IM) & IE & ~EXL.
REQ-025 States are IDLE, FLUSH and REDIRECT; Busy = (state != IDLE).
REQ-026 In IDLE, the event priority is: IntPend, then any SrcExcGet, then EretReq. Exactly one event is accepted per edge; all other inputs are ignored.
REQ-027 On an accepted interrupt, latch ExcCode = 5'd0, with PC and BD taken from slot 0.
REQ-028 On an accepted exception, select the lowest index i with SrcExcGet[i] = 1, and latch its code, PC and BD.
REQ-029 For an interrupt or exception, latch EPC = BD ? PC-4 : PC (modulo 2^32) and RedirectPC = HANDLER_PC.
REQ-030 For ERET, latch RedirectPC = EPCIn as sampled at acceptance.
REQ-031 On acceptance, transition IDLE->FLUSH and load the counter with FLUSH_CYC-1. The counter width is $clog2(FLUSH_CYC+1).
REQ-032 In FLUSH: Flush = 1; decrement the counter each cycle; at counter = 0, transition FLUSH->REDIRECT.
REQ-033 In REDIRECT: assert Redirect = 1 for exactly one cycle, then transition to IDLE.
REQ-034 In REDIRECT, for an interrupt or exception: SetEXL = 1, and EPCWe = 1 only if EXL was 0 at acceptance, so that a nested exception does not overwrite EPC.
REQ-035 In REDIRECT, for ERET: ClrEXL = 1 and EPCWe = 0.
REQ-036 Latency: an event accepted at edge k yields Flush high during cycles k+1..k+FLUSH_CYC and Redirect high during cycle k+FLUSH_CYC+1.
REQ-037 An interrupt adds 2 cycles of synchronizer latency.
REQ-038 ExcCodeOut, EPCOut, BDOut and RedirectPC shall hold their latched values from acceptance until the next acceptance.
REQ-039 Events arriving while Busy = 1 are dropped; the pipeline shall hold them until Busy = 0.
REQ-040 Simultaneous SrcExcGet and EretReq: the exception wins, and the ERET is discarded with the flush.

Reset
REQ-041 Asserting reset at any time, including mid-FLUSH, shall force IDLE immediately.
REQ-042 On reset: counter = 0, synchronizer flops = 0, all outputs = 0, and latched registers = 0.
REQ-043 Deassertion of reset is ignored in the same cycle; the first acceptance occurs no earlier than the first full clock edge after release.

Verification
REQ-044 SrcExcGet = 4'b0110, codes 10/12 in slots 1/2, SrcPC[1] = 32'h3008, BD = 0, EXL = 0 -> ExcCodeOut = 10, EPCOut = 32'h3008, Flush for 2 cycles, then Redirect with RedirectPC = 32'h4180, EPCWe = 1, SetEXL = 1.
REQ-045 Slot 0 exception with BD = 1 and PC = 32'h3010 -> EPCOut = 32'h300C, BDOut = 1.
REQ-046 HWInt[2] = 1, IM = 6'b000100, IE = 1, EXL = 0 -> Busy rises 3 edges later, ExcCodeOut = 0; with IM = 0, or with EXL = 1 -> no response.
REQ-047 EretReq = 1, EPCIn = 32'h3020 -> Redirect with RedirectPC = 32'h3020, ClrEXL = 1, EPCWe = 0.
REQ-048 Exception raised with EXL = 1 -> Redirect to 32'h4180, SetEXL = 1, EPCWe = 0.
REQ-049 Reset asserted in the first FLUSH cycle -> Flush = 0 immediately, no Redirect; a new exception after release yields normal FLUSH_CYC timing.
